// File: rtl/gpio_pkg.sv
// Shared constants and types for the GPIO blocks: header widths, default PWM
// timing and the duty write-port state encoding.
package gpio_pkg;

    localparam int GPIO_WIDTH   = 36;
    localparam int LEDG_WIDTH   = 9;

    // 8-bit PWM at 50 MHz / 195 gives roughly a 1 kHz period.
    localparam int PWM_BITS_DEF = 8;
    localparam int PRESCALE_DEF = 195;

    typedef enum logic {
        WR_IDLE = 1'b0,
        WR_PEND = 1'b1
    } wr_state_t;

endpackage

// File: rtl/gpio_pwm_tick.sv
// Common PWM timebase: a prescaler producing one tick every PRESCALE clocks
// and a free-running PWM counter advanced by that tick. Both are held at zero
// while disabled so a fresh enable always starts a full period.
module gpio_pwm_tick
    import gpio_pkg::*;
#(
    parameter int PWM_BITS = PWM_BITS_DEF,
    parameter int PRESCALE = PRESCALE_DEF
) (
    input  logic                clock_50,
    input  logic                reset_n,
    input  logic                enable,
    output logic                tick,
    output logic [PWM_BITS-1:0] pwm_cnt,
    output logic                period_start
);

    localparam int              PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]   PRE_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0]       presc_reg;
    logic [PWM_BITS-1:0] cnt_reg;
    logic                period_start_reg;
    logic                wrap;

    assign tick         = enable && (presc_reg == PRE_LAST);
    assign wrap         = tick && (cnt_reg == '1);
    assign pwm_cnt      = cnt_reg;
    assign period_start = period_start_reg;

    // Prescaler: counts 0..PRESCALE-1, restarts on tick, parked at 0 when disabled.
    always_ff @(posedge clock_50 or negedge reset_n) begin
        if (!reset_n) begin
            presc_reg <= '0;
        end else if (!enable || tick) begin
            presc_reg <= '0;
        end else begin
            presc_reg <= presc_reg + 1'b1;
        end
    end

    // PWM counter: advances once per tick and wraps naturally at all-ones.
    always_ff @(posedge clock_50 or negedge reset_n) begin
        if (!reset_n) begin
            cnt_reg <= '0;
        end else if (!enable) begin
            cnt_reg <= '0;
        end else if (tick) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    // Period-start pulse: high during the cycle the counter has just wrapped to 0.
    always_ff @(posedge clock_50 or negedge reset_n) begin
        if (!reset_n) begin
            period_start_reg <= 1'b0;
        end else begin
            period_start_reg <= wrap;
        end
    end

endmodule

// File: rtl/gpio_pwm_drv.sv
// Multi-channel PWM driver for the header LEDs. Duty writes land in a shadow
// copy and are copied to the live compare value only at a period boundary, so
// a pin never sees a partial period. While disabled every cycle counts as a
// boundary so duties are already live when the PWM starts.
// reset_n is expected to be deasserted synchronously to clock_50 upstream.
module gpio_pwm_drv
    import gpio_pkg::*;
#(
    parameter int CHANNELS = LEDG_WIDTH,
    parameter int PWM_BITS = PWM_BITS_DEF,
    parameter int PRESCALE = PRESCALE_DEF
) (
    input  logic                clock_50,
    input  logic                reset_n,
    input  logic                enable,
    input  logic [3:0]          duty_chan,
    input  logic [PWM_BITS-1:0] duty_data,
    input  logic                duty_valid,
    output logic                duty_ready,
    output logic                duty_err,
    output logic                period_start,
    output logic [CHANNELS-1:0] gpio_out,
    output logic [CHANNELS-1:0] gpio_oe
);

    localparam logic [4:0] CH_LIM = 5'(CHANNELS);

    logic                tick;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic                boundary;
    logic                commit;
    logic                wr_fire;
    logic                chan_ok;
    logic                wr_accept;

    wr_state_t           state_reg;
    wr_state_t           state_next;

    logic                err_reg;
    logic                oe_reg;

    logic [PWM_BITS-1:0] shadow_reg [CHANNELS];
    logic [PWM_BITS-1:0] active_reg [CHANNELS];
    logic                dirty_reg  [CHANNELS];
    logic                out_reg    [CHANNELS];

    gpio_pwm_tick #(
        .PWM_BITS (PWM_BITS),
        .PRESCALE (PRESCALE)
    ) u_tick (
        .clock_50     (clock_50),
        .reset_n      (reset_n),
        .enable       (enable),
        .tick         (tick),
        .pwm_cnt      (pwm_cnt),
        .period_start (period_start)
    );

    // A boundary is the counter wrap, or any cycle at all while disabled.
    assign boundary  = !enable || (tick && (pwm_cnt == '1));
    assign commit    = (state_reg == WR_PEND) && boundary;
    assign wr_fire   = duty_valid && duty_ready;
    assign chan_ok   = ({1'b0, duty_chan} < CH_LIM);
    assign wr_accept = wr_fire && chan_ok;

    // Write-port state register.
    always_ff @(posedge clock_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= WR_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state: any accepted write makes the port pending until the next commit.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            WR_IDLE: if (wr_accept) state_next = WR_PEND;
            WR_PEND: if (commit)    state_next = WR_IDLE;
            default: state_next = WR_IDLE;
        endcase
    end

    // Ready drops only in the commit cycle so a write can never race the copy.
    always_comb begin
        duty_ready = 1'b1;
        if (state_reg == WR_PEND && boundary) begin
            duty_ready = 1'b0;
        end
    end

    // Error pulse and registered enable for the pin output enables.
    always_ff @(posedge clock_50 or negedge reset_n) begin
        if (!reset_n) begin
            err_reg <= 1'b0;
            oe_reg  <= 1'b0;
        end else begin
            err_reg <= wr_fire && !chan_ok;
            oe_reg  <= enable;
        end
    end

    assign duty_err = err_reg;
    assign gpio_oe  = {CHANNELS{oe_reg}};

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
        logic hit;
        assign hit = wr_accept && (duty_chan == 4'(gi));

        // Shadow/dirty capture and boundary commit into the live duty.
        always_ff @(posedge clock_50 or negedge reset_n) begin
            if (!reset_n) begin
                shadow_reg[gi] <= '0;
                active_reg[gi] <= '0;
                dirty_reg[gi]  <= 1'b0;
            end else begin
                if (commit && dirty_reg[gi]) begin
                    active_reg[gi] <= shadow_reg[gi];
                end
                if (hit) begin
                    shadow_reg[gi] <= duty_data;
                    dirty_reg[gi]  <= 1'b1;
                end else if (commit) begin
                    dirty_reg[gi]  <= 1'b0;
                end
            end
        end

        // Registered compare; all-ones duty is forced high to avoid a one-tick gap.
        always_ff @(posedge clock_50 or negedge reset_n) begin
            if (!reset_n) begin
                out_reg[gi] <= 1'b0;
            end else begin
                out_reg[gi] <= enable &&
                               ((active_reg[gi] == '1) || (pwm_cnt < active_reg[gi]));
            end
        end

        assign gpio_out[gi] = out_reg[gi];
    end

endmodule
